core_mem_arbiter: RTL and testbench

- Shares one downstream memory port between the instruction-fetch requester and the data (load/store) requester of the pipelined core.
- Sits between the core's fetch/memory stages and the single memory/cache port.
- Serialises transactions with one outstanding at a time.
- Data has fixed priority; an optional starvation guard forces fetch progress.

---
 rtl/core_mem_arbiter.sv | 112 +++++++++++
 tb/tb_core_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: serialises fetch and data requests onto one memory port, data-first; `ARB_STARVE_GUARD_EN adds a fetch starvation guard
module core_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  input  logic [7:0]        d_wstrb,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [63:0]       m_wdata,
  output logic [7:0]        m_wstrb,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [63:0]       m_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t      state;
  logic        own_d;
  logic        word_sel;
  logic [63:0] rdata;
  logic        force_i;
  logic        grant_d;
  logic        grant_i;
  logic        unused_bits;
  assign unused_bits = ^{i_addr[1:0], d_addr[2:0]};
`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;
  assign force_i = starve_cnt == CW'(STARVE_MAX);
  // count data grants that made a waiting fetch lose; any fetch grant or idle fetch clears it
  always_ff @(posedge clock) begin
    if (reset) starve_cnt <= '0;
    else if (grant_i || (state == IDLE && !i_req)) starve_cnt <= '0;
    else if (grant_d && !force_i) starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign force_i = 1'b0;
`endif
  assign grant_d  = state == IDLE && d_req && !(i_req && force_i);
  assign grant_i  = state == IDLE && i_req && !grant_d;
  assign i_ready  = grant_i;
  assign d_ready  = grant_d;
  assign m_req    = state == REQ;
  assign i_rvalid = state == RESP && !own_d;
  assign d_rvalid = state == RESP && own_d;
  assign i_rdata  = word_sel ? rdata[63:32] : rdata[31:0];
  assign d_rdata  = rdata;
  // transaction FSM: latch the granted request, hold it through the handshake, capture the response
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      own_d    <= 1'b0;
      word_sel <= 1'b0;
      rdata    <= '0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            own_d   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= {d_addr[ADDR_W-1:3], 3'b000};
            m_wdata <= d_wdata;
            m_wstrb <= d_wstrb;
            state   <= REQ;
          end else if (grant_i) begin
            own_d    <= 1'b0;
            word_sel <= i_addr[2];
            m_we     <= 1'b0;
            m_addr   <= {i_addr[ADDR_W-1:3], 3'b000};
            m_wdata  <= '0;
            m_wstrb  <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (m_ready && m_rvalid) begin
            rdata <= m_rdata;
            state <= RESP;
          end else if (m_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (m_rvalid) begin
            rdata <= m_rdata;
            state <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed-vector bench for core_mem_arbiter
module tb_core_mem_arbiter;
  logic        clock = 0;
  logic        reset = 1;
  logic        i_req = 0;
  logic [63:0] i_addr = 0;
  logic        i_ready, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 0, d_we = 0;
  logic [63:0] d_addr = 0, d_wdata = 0;
  logic [7:0]  d_wstrb = 0;
  logic        d_ready, d_rvalid;
  logic [63:0] d_rdata;
  logic        m_req, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_ready = 0, m_rvalid = 0;
  logic [63:0] m_rdata = 0;
  int vectors = 0;
  int miscompares = 0;

  core_mem_arbiter #(.ADDR_W(64), .STARVE_MAX(2)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clock = ~clock;

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    #1;
    vectors++;
    if ({i_ready, d_ready, m_req, i_rvalid, d_rvalid, m_we} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b exp 000000", {i_ready, d_ready, m_req, i_rvalid, d_rvalid, m_we});
    end
    vectors++;
    if ({m_addr, m_wdata, m_wstrb, i_rdata, d_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got m_addr=%h m_wdata=%h m_wstrb=%h i_rdata=%h d_rdata=%h exp all 0", m_addr, m_wdata, m_wstrb, i_rdata, d_rdata);
    end
    cyc();
  endtask

  task automatic test_fetch;
    i_req = 1; i_addr = 64'h8000_0004;
    #1;
    vectors++;
    if ({i_ready, d_ready} !== 2'b10) begin
      miscompares++; $display("FAIL fetch_grant got %b exp 10", {i_ready, d_ready});
    end
    cyc();
    i_req = 0; m_ready = 1; m_rvalid = 1; m_rdata = 64'h1111_2222_3333_4444;
    #1;
    vectors++;
    if ({m_req, m_we, m_wstrb, i_rvalid} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      miscompares++; $display("FAIL fetch_mreq got req=%b we=%b strb=%h rv=%b exp 1 0 00 0", m_req, m_we, m_wstrb, i_rvalid);
    end
    vectors++;
    if (m_addr !== 64'h8000_0000) begin
      miscompares++; $display("FAIL fetch_addr got %h exp 0000000080000000", m_addr);
    end
    cyc();
    m_ready = 0; m_rvalid = 0;
    #1;
    vectors++;
    if ({i_rvalid, d_rvalid, i_rdata} !== {2'b10, 32'h1111_2222}) begin
      miscompares++; $display("FAIL fetch_resp got rv=%b%b data=%h exp 10 11112222", i_rvalid, d_rvalid, i_rdata);
    end
    cyc();
    vectors++;
    if (i_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL fetch_pulse got %b exp 0", i_rvalid);
    end
  endtask

  task automatic test_store;
    d_req = 1; d_we = 1; d_addr = 64'h100; d_wdata = 64'hDEAD_BEEF_0000_0001; d_wstrb = 8'h0F;
    #1;
    vectors++;
    if ({d_ready, i_ready} !== 2'b10) begin
      miscompares++; $display("FAIL store_grant got %b exp 10", {d_ready, i_ready});
    end
    cyc();
    d_req = 0; d_we = 0; d_wdata = 0; d_wstrb = 0; m_ready = 1;
    #1;
    vectors++;
    if ({m_req, m_we, m_addr, m_wdata, m_wstrb} !== {1'b1, 1'b1, 64'h100, 64'hDEAD_BEEF_0000_0001, 8'h0F}) begin
      miscompares++; $display("FAIL store_fields got req=%b we=%b addr=%h wdata=%h strb=%h", m_req, m_we, m_addr, m_wdata, m_wstrb);
    end
    cyc();
    m_ready = 0; m_rvalid = 1;
    #1;
    vectors++;
    if ({m_req, d_rvalid} !== 2'b00) begin
      miscompares++; $display("FAIL store_wait got req=%b rv=%b exp 00", m_req, d_rvalid);
    end
    cyc();
    m_rvalid = 0;
    #1;
    vectors++;
    if ({d_rvalid, i_rvalid} !== 2'b10) begin
      miscompares++; $display("FAIL store_ack got %b exp 10", {d_rvalid, i_rvalid});
    end
    cyc();
  endtask

  task automatic test_priority;
    i_req = 1; i_addr = 64'h10; d_req = 1; d_we = 0; d_addr = 64'h200;
    #1;
    vectors++;
    if ({d_ready, i_ready} !== 2'b10) begin
      miscompares++; $display("FAIL prio_first got d/i=%b exp 10", {d_ready, i_ready});
    end
    cyc();
    d_req = 0; m_ready = 1; m_rvalid = 1; m_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    vectors++;
    if ({i_ready, m_addr} !== {1'b0, 64'h200}) begin
      miscompares++; $display("FAIL prio_dreq got i_ready=%b addr=%h exp 0 200", i_ready, m_addr);
    end
    cyc();
    m_ready = 0; m_rvalid = 0;
    #1;
    vectors++;
    if ({d_rvalid, i_ready, d_rdata} !== {2'b10, 64'hAAAA_BBBB_CCCC_DDDD}) begin
      miscompares++; $display("FAIL prio_dresp got rv=%b i_ready=%b data=%h", d_rvalid, i_ready, d_rdata);
    end
    cyc();
    vectors++;
    if (i_ready !== 1'b1) begin
      miscompares++; $display("FAIL prio_second got i_ready=%b exp 1", i_ready);
    end
    cyc();
    i_req = 0; m_ready = 1; m_rvalid = 1; m_rdata = 64'h0123_4567_89AB_CDEF;
    #1;
    vectors++;
    if ({m_req, m_addr} !== {1'b1, 64'h10}) begin
      miscompares++; $display("FAIL prio_ireq got req=%b addr=%h exp 1 10", m_req, m_addr);
    end
    cyc();
    m_ready = 0; m_rvalid = 0;
    #1;
    vectors++;
    if ({i_rvalid, i_rdata} !== {1'b1, 32'h89AB_CDEF}) begin
      miscompares++; $display("FAIL prio_iresp got rv=%b data=%h exp 1 89abcdef", i_rvalid, i_rdata);
    end
    cyc();
  endtask

  task automatic test_stall;
    int pulses = 0;
    i_req = 1; i_addr = 64'h2000_000C;
    #1;
    vectors++;
    if (i_ready !== 1'b1) begin
      miscompares++; $display("FAIL stall_grant got %b exp 1", i_ready);
    end
    cyc();
    i_req = 0;
    for (int k = 0; k < 5; k++) begin
      m_rvalid = (k == 2);
      #1;
      vectors++;
      if ({m_req, m_we, m_addr, m_wstrb, i_rvalid} !== {2'b10, 64'h2000_0008, 8'h00, 1'b0}) begin
        miscompares++; $display("FAIL stall_hold%0d got req=%b we=%b addr=%h strb=%h rv=%b", k, m_req, m_we, m_addr, m_wstrb, i_rvalid);
      end
      cyc();
    end
    m_rvalid = 0; m_ready = 1;
    cyc();
    m_ready = 0;
    for (int k = 0; k < 3; k++) begin
      m_rvalid = (k == 2); m_rdata = (k == 2) ? 64'hCAFE_F00D_1234_5678 : 64'h0;
      #1;
      pulses += i_rvalid;
      cyc();
    end
    m_rvalid = 0;
    #1;
    vectors++;
    if ({i_rvalid, i_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      miscompares++; $display("FAIL stall_resp got rv=%b data=%h exp 1 cafef00d", i_rvalid, i_rdata);
    end
    pulses += i_rvalid;
    cyc();
    for (int k = 0; k < 3; k++) begin
      m_rvalid = (k < 2);
      #1;
      pulses += i_rvalid + d_rvalid;
      vectors++;
      if ({m_req, i_ready, d_ready} !== 3'b000) begin
        miscompares++; $display("FAIL stall_idle%0d got req/ir/dr=%b exp 000", k, {m_req, i_ready, d_ready});
      end
      cyc();
    end
    m_rvalid = 0;
    vectors++;
    if (pulses !== 1) begin
      miscompares++; $display("FAIL stall_pulses got %0d exp 1", pulses);
    end
  endtask

  task automatic test_reset_mid;
    d_req = 1; d_we = 0; d_addr = 64'h300;
    cyc();
    d_req = 0; m_ready = 1;
    cyc();
    m_ready = 0; reset = 1;
    cyc();
    reset = 0; m_rvalid = 1; m_rdata = 64'h5555_6666_7777_8888;
    #1;
    vectors++;
    if ({m_req, d_rvalid, i_rvalid, m_addr, d_rdata} !== '0) begin
      miscompares++; $display("FAIL rstmid_clear got req=%b drv=%b irv=%b addr=%h data=%h exp all 0", m_req, d_rvalid, i_rvalid, m_addr, d_rdata);
    end
    cyc();
    m_rvalid = 0;
    #1;
    vectors++;
    if ({d_rvalid, i_rvalid, m_req, d_rdata} !== '0) begin
      miscompares++; $display("FAIL rstmid_late got drv=%b irv=%b req=%b data=%h exp all 0", d_rvalid, i_rvalid, m_req, d_rdata);
    end
    i_req = 1; i_addr = 64'h40;
    #1;
    vectors++;
    if (i_ready !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_grant got %b exp 1", i_ready);
    end
    cyc();
    i_req = 0; m_ready = 1; m_rvalid = 1; m_rdata = 64'h9999_0000_4242_4242;
    cyc();
    m_ready = 0; m_rvalid = 0;
    #1;
    vectors++;
    if ({i_rvalid, i_rdata} !== {1'b1, 32'h4242_4242}) begin
      miscompares++; $display("FAIL rstmid_resp got rv=%b data=%h exp 1 42424242", i_rvalid, i_rdata);
    end
    cyc();
  endtask

  task automatic test_starve;
    logic exp_i;
    i_req = 1; i_addr = 64'h80; d_req = 1; d_we = 0; d_addr = 64'h400;
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_i = (k % 3) == 2;
`else
      exp_i = 1'b0;
`endif
      #1;
      vectors++;
      if ({i_ready, d_ready} !== {exp_i, ~exp_i}) begin
        miscompares++; $display("FAIL starve_grant%0d got i/d=%b%b exp %b%b", k, i_ready, d_ready, exp_i, ~exp_i);
      end
      cyc();
      m_ready = 1; m_rvalid = 1;
      cyc();
      m_ready = 0; m_rvalid = 0;
      cyc();
    end
    i_req = 0; d_req = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_priority();
    test_stall();
    test_reset_mid();
    test_starve();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
